aes_enc_iter: RTL and testbench



---
 rtl/aes_enc_pkg.sv | 35 +++
 rtl/aes_enc_round.sv | 42 ++++
 rtl/aes_key_scheduling.sv | 29 ++
 rtl/aes_enc_iter.sv | 96 +++++++++
 tb/tb_aes_enc_iter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/aes_enc_pkg.sv
// Shared types, constants and byte-level helpers for the iterative AES-128 encryptor.
// The FSM state type is exported here so checkers can bind to the top's state_q.
package aes_enc_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [7:0]   byte_t;
  typedef logic [3:0]   round_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam round_t LAST_ROUND = 4'hA;
  localparam byte_t  RCON_INIT  = 8'h01;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t sbox(input byte_t b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round: ShiftRows, SubBytes, MixColumns (skipped on the last
// round) and AddRoundKey. Byte i of the block sits at [127-8i -: 8], column-major.
module aes_enc_round
  import aes_enc_pkg::*;
(
  input  aes_block_t blk,
  input  aes_block_t round_key,
  input  logic       last_round,
  output aes_block_t blk_next
);

  aes_block_t sub;
  aes_block_t mixed;

  function automatic aes_word_t mix_column(input aes_word_t w);
    byte_t a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    sub = '0;
    // Row r of column c takes the byte from column (c+r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub[127 - 8 * (r + 4 * c) -: 8] = sbox(blk[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8]);
      end
    end
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32 * c -: 32] = mix_column(sub[127 - 32 * c -: 32]);
    end
    blk_next = (last_round ? sub : mixed) ^ round_key;
  end

endmodule

// File: rtl/aes_key_scheduling.sv
// One step of the AES-128 forward key expansion: current round key plus rcon in,
// next round key out. Purely combinational.
module aes_key_scheduling
  import aes_enc_pkg::*;
(
  input  aes_block_t key,
  input  byte_t      rcon,
  output aes_block_t key_next
);

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot, temp;
  aes_word_t n0, n1, n2, n3;

  always_comb begin
    w0   = key[127:96];
    w1   = key[95:64];
    w2   = key[63:32];
    w3   = key[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    key_next = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor, one round per clock, with valid/ready on both sides.
// Define AES_ENC_LAST_KEY_OUT_EN to expose the final round key on key_last_out.
module aes_enc_iter
  import aes_enc_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       data_valid_in,
  output logic       data_ready_out,
  input  aes_block_t data_in,
  input  aes_block_t key_in,
  output aes_block_t res_enc_out,
  output logic       res_valid_out,
  input  logic       res_ready_in
`ifdef AES_ENC_LAST_KEY_OUT_EN
  ,
  output aes_block_t key_last_out
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and ready is decoded from state only.

  state_t     state_q, state_d;
  round_t     round_q;
  aes_block_t data_q, key_q, res_q;
  byte_t      rcon_q;
  aes_block_t round_key, round_out;
  logic       accept, last_round;

  assign data_ready_out = (state_q == IDLE);
  assign res_valid_out  = (state_q == DONE);
  assign res_enc_out    = res_q;
  assign accept         = data_valid_in & data_ready_out;
  assign last_round     = (round_q == LAST_ROUND);

  aes_key_scheduling u_key_sched (
    .key      (key_q),
    .rcon     (rcon_q),
    .key_next (round_key)
  );

  aes_enc_round u_round (
    .blk        (data_q),
    .round_key  (round_key),
    .last_round (last_round),
    .blk_next   (round_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (last_round) state_d = DONE;
      DONE:    if (res_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      round_q <= '0;
      data_q  <= '0;
      key_q   <= '0;
      rcon_q  <= RCON_INIT;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q  <= data_in ^ key_in;
        key_q   <= key_in;
        rcon_q  <= RCON_INIT;
        round_q <= 4'd1;
      end else if (state_q == ROUND) begin
        data_q <= round_out;
        key_q  <= round_key;
        rcon_q <= xtime(rcon_q);
        // The result gets its own register so it survives the next block's rounds.
        if (last_round) res_q <= round_out;
        else            round_q <= round_q + 4'd1;
      end
    end
  end

`ifdef AES_ENC_LAST_KEY_OUT_EN
  aes_block_t key_last_q;
  assign key_last_out = key_last_q;

  always_ff @(posedge clk) begin
    if (!resetn)                                key_last_q <= '0;
    else if ((state_q == ROUND) && last_round)  key_last_q <= round_key;
  end
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter using the FIPS-197 vectors, backpressure,
// input-change-after-accept and mid-round reset scenarios.
module tb_aes_enc_iter;
  import aes_enc_pkg::*;

  localparam aes_block_t KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_block_t PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam aes_block_t CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam aes_block_t LK_B   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam aes_block_t KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_block_t PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam aes_block_t CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam aes_block_t LK_C1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       data_valid_in = 1'b0;
  logic       data_ready_out;
  aes_block_t data_in = '0;
  aes_block_t key_in = '0;
  aes_block_t res_enc_out;
  logic       res_valid_out;
  logic       res_ready_in = 1'b0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  aes_block_t key_last_out;
`endif

  int passed = 0;
  int total  = 0;
  int lat;

  always #5 clk = ~clk;

  aes_enc_iter dut (
    .clk            (clk),
    .resetn         (resetn),
    .data_valid_in  (data_valid_in),
    .data_ready_out (data_ready_out),
    .data_in        (data_in),
    .key_in         (key_in),
    .res_enc_out    (res_enc_out),
    .res_valid_out  (res_valid_out),
    .res_ready_in   (res_ready_in)
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    .key_last_out   (key_last_out)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic aes_block_t rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Presents one block; returns at the falling edge right after the accept edge.
  task automatic start(input aes_block_t pt, input aes_block_t key, input bit scramble);
    @(negedge clk);
    data_in       = pt;
    key_in        = key;
    data_valid_in = 1'b1;
    @(negedge clk);
    data_valid_in = 1'b0;
    if (scramble) begin
      data_in = rand_block();
      key_in  = rand_block();
    end
  endtask

  // Counts falling edges after accept until res_valid_out, bounded.
  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid_out && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake(input aes_block_t ct);
    res_ready_in = 1'b1;
    @(negedge clk);
    res_ready_in = 1'b0;
    check("hs_valid_low", res_valid_out, 0);
    check("hs_ready_high", data_ready_out, 1);
    check("hs_res_held", res_enc_out, ct);
  endtask

  initial begin
    // Reset
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_ready", data_ready_out, 1);
    check("rst_valid", res_valid_out, 0);
    check("rst_res", res_enc_out, 0);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    check("rst_key_last", key_last_out, 0);
`endif

    // FIPS-197 Appendix B with latency check; res_ready_in high during rounds is harmless
    start(PT_B, KEY_B, 0);
    check("b_busy_ready", data_ready_out, 0);
    res_ready_in = 1'b1;
    @(negedge clk);
    res_ready_in = 1'b0;
    lat = 1;
    while (!res_valid_out && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b_latency", lat, 10);
    check("b_ct", res_enc_out, CT_B);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    check("b_key_last", key_last_out, LK_B);
`endif
    handshake(CT_B);

    // FIPS-197 C.1 followed by 20 cycles of backpressure with ignored input pulses
    start(PT_C1, KEY_C1, 0);
    wait_result(lat);
    check("c1_latency", lat, 10);
    check("c1_ct", res_enc_out, CT_C1);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    check("c1_key_last", key_last_out, LK_C1);
`endif
    for (int i = 0; i < 20; i++) begin
      data_valid_in = 1'($urandom_range(0, 1));
      data_in       = rand_block();
      key_in        = rand_block();
      @(negedge clk);
      check("bp_valid", res_valid_out, 1);
      check("bp_ct_stable", res_enc_out, CT_C1);
      check("bp_ready_low", data_ready_out, 0);
    end
    data_valid_in = 1'b0;
    handshake(CT_C1);

    // Inputs change the cycle after accept; result must be unaffected
    start(PT_B, KEY_B, 1);
    wait_result(lat);
    check("chg_latency", lat, 10);
    check("chg_ct", res_enc_out, CT_B);
    handshake(CT_B);

    // Reset for one cycle in the middle of the rounds
    start(PT_B, KEY_B, 0);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("mid_rst_valid", res_valid_out, 0);
    check("mid_rst_res", res_enc_out, 0);
    check("mid_rst_ready", data_ready_out, 1);
    repeat (12) @(negedge clk);
    check("mid_rst_no_valid", res_valid_out, 0);

    // Encryption after the abort must still be correct
    start(PT_B, KEY_B, 0);
    wait_result(lat);
    check("post_rst_latency", lat, 10);
    check("post_rst_ct", res_enc_out, CT_B);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    check("post_rst_key_last", key_last_out, LK_B);
`endif
    handshake(CT_B);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
